// File: rtl/wb_ram_stream_pkg.sv
// wb_ram_stream_pkg: shared types for the Wishbone RAM stream reader.
// Exports the FSM state enum and the fixed byte-select value.
package wb_ram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] WB_SEL_ALL = 4'hF;

endpackage

// File: rtl/wb_ram_stream_fifo.sv
// wb_ram_stream_fifo: synchronous FIFO buffering read words for the stream.
// Ports: push_i/din_i write, pop_i read (dout_o = head), flush_i empties,
// full_o/empty_o/count_o status; async active-high rst.
module wb_ram_stream_fifo
  import wb_ram_stream_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  // A pop frees the head slot, so a full FIFO can take a push that cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (do_push & ~flush_i) begin
      mem_q[wr_q] <= din_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/wb_ram_stream_reader.sv
// wb_ram_stream_reader: bursts len words from a Wishbone RAM port
// (pipelined master) and delivers them in order on a valid/ready stream.
// Ports: start_i/base_adr_i/len_i command, busy_o/done_o/err_o status,
// wb_* master bus, m_data_o/m_valid_o/m_ready_i/m_last_o stream.
module wb_ram_stream_reader
  import wb_ram_stream_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_adr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  input  logic [31:0]           wb_dat_i,
  output logic                  wb_we_o,
  output logic [3:0]            wb_sel_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  input  logic                  wb_stall_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  output logic [31:0]           m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int LW = ADDR_WIDTH + 1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         iss_q, iss_d;
  logic [LW-1:0]         pop_q, pop_d;
  logic [CW-1:0]         out_q, out_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [CW-1:0] fcnt;
  logic [31:0]   fdout;
  logic          fempty;
  logic          ffull;
  logic          stb;
  logic          accept;
  logic          ack;
  logic          pop;
  logic          flush;
  logic          last;
  logic [CW:0]   credit;

  // Every in-flight read owns a FIFO slot, so the buffer can never overflow.
  assign credit = {1'b0, out_q} + {1'b0, fcnt};
  assign stb    = (state_q == READ) && (iss_q < len_q) && !ffull
                  && (credit < (CW+1)'(FIFO_DEPTH));
  assign accept = stb & ~wb_stall_i;
  assign ack    = (state_q == READ) & wb_ack_i;
  assign flush  = (state_q == READ) & wb_err_i;
  assign pop    = ~fempty & m_ready_i;
  assign last   = ((pop_q + LW'(1)) == len_q);

  wb_ram_stream_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ack),
    .din_i   (wb_dat_i),
    .pop_i   (pop),
    .flush_i (flush),
    .dout_o  (fdout),
    .full_o  (ffull),
    .empty_o (fempty),
    .count_o (fcnt)
  );

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    len_d   = len_q;
    iss_d   = iss_q;
    pop_d   = pop_q;
    out_d   = out_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (pop) pop_d = pop_q + LW'(1);
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = READ;
            adr_d   = base_adr_i;
            len_d   = len_i;
            iss_d   = '0;
            pop_d   = '0;
            out_d   = '0;
          end
        end
      end
      READ: begin
        if (wb_err_i) begin
          state_d = IDLE;
          out_d   = '0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          if (accept) begin
            adr_d = adr_q + ADDR_WIDTH'(1);
            iss_d = iss_q + LW'(1);
          end
          out_d = out_q + CW'(accept) - CW'(ack);
          // Look at next-state counts so cyc drops right after the last ack.
          if (iss_d == len_q && out_d == '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      len_q   <= '0;
      iss_q   <= '0;
      pop_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      len_q   <= len_d;
      iss_q   <= iss_d;
      pop_q   <= pop_d;
      out_q   <= out_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy_o    = (state_q != IDLE);
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign wb_adr_o  = adr_q;
  assign wb_we_o   = 1'b0;
  assign wb_sel_o  = WB_SEL_ALL;
  assign wb_cyc_o  = (state_q == READ);
  assign wb_stb_o  = stb;
  assign m_valid_o = ~fempty;
  assign m_data_o  = fempty ? 32'd0 : fdout;
  assign m_last_o  = ~fempty & last;

endmodule

// File: tb/tb_wb_ram_stream_reader.sv
// tb_wb_ram_stream_reader: scoreboard bench with a RAM slave model
// (1-cycle ack, classic stall=!ack, random stall) and random traffic.
module tb_wb_ram_stream_reader;

  localparam int AW = 14;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0;
  logic [AW:0]   len = '0;
  logic          busy_o, done_o, err_o;
  logic [AW-1:0] wb_adr_o;
  logic [31:0]   dat = '0;
  logic          wb_we_o;
  logic [3:0]    wb_sel_o;
  logic          wb_cyc_o, wb_stb_o;
  logic          stall = 1'b0;
  logic          ack = 1'b0;
  logic          err = 1'b0;
  logic [31:0]   m_data_o;
  logic          m_valid_o;
  logic          ready = 1'b0;
  logic          m_last_o;

  wb_ram_stream_reader #(.ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .base_adr_i (base),
    .len_i      (len),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_i   (dat),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_stall_i (stall),
    .wb_ack_i   (ack),
    .wb_err_i   (err),
    .m_data_o   (m_data_o),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (ready),
    .m_last_o   (m_last_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  logic [31:0]   mem [1<<AW];
  exp_t          q[$];
  int            checks = 0;
  int            fails = 0;
  int            cyc_n = 0;
  int            mode = 0;
  int            rdy_pct = 100;
  int            err_at = 0;
  int            ack_cnt = 0;
  int            acc_cnt = 0;
  int            first_acc = -1;
  int            last_acc = -1;
  int            last_hs = -1;
  int            hs_cnt = 0;
  int            cyc_seen = 0;
  int            st_cyc = 0;
  logic [AW-1:0] exp_base = '0;
  logic          aborting = 1'b0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint exp);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: actual %0h expected %0h", nm, act, exp);
    end
  endtask

  // RAM slave plus ready driver: sample bus at negedge, drive after posedge.
  initial begin
    logic          s_hit;
    logic          s_stb;
    logic [AW-1:0] s_adr;
    s_hit = 1'b0;
    s_stb = 1'b0;
    s_adr = '0;
    forever begin
      @(negedge clk);
      s_hit = wb_cyc_o & wb_stb_o & ~stall;
      s_stb = wb_cyc_o & wb_stb_o;
      s_adr = wb_adr_o;
      @(posedge clk);
      #1;
      ready = ($urandom_range(0, 99) < rdy_pct);
      err = 1'b0;
      if (rst) begin
        ack = 1'b0;
        stall = 1'b0;
      end else if (mode == 1) begin
        ack = s_stb & ~ack;
        stall = ~ack;
        dat = mem[wb_adr_o];
      end else begin
        ack = 1'b0;
        if (s_hit) begin
          ack_cnt++;
          if (ack_cnt == err_at) err = 1'b1;
          else begin
            ack = 1'b1;
            dat = mem[s_adr];
          end
        end
        stall = (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      end
    end
  end

  // Monitor: address order, stall stability, scoreboard pops.
  initial begin
    logic          p_stb;
    logic          p_stall;
    logic          p_err;
    logic [AW-1:0] p_adr;
    logic [AW-1:0] ea;
    exp_t          e;
    p_stb = 1'b0;
    p_stall = 1'b0;
    p_err = 1'b0;
    p_adr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (wb_cyc_o) cyc_seen++;
        if (wb_cyc_o && wb_stb_o && !stall) begin
          ea = exp_base + AW'(acc_cnt);
          chk(wb_adr_o == ea, "adr", wb_adr_o, ea);
          acc_cnt++;
          if (first_acc < 0) first_acc = cyc_n;
          last_acc = cyc_n;
        end
        if (p_stb && p_stall && !p_err)
          chk(wb_stb_o && wb_adr_o == p_adr, "stall_hold",
              {wb_stb_o, wb_adr_o}, {1'b1, p_adr});
        if (m_valid_o && ready) begin
          hs_cnt++;
          last_hs = cyc_n;
          if (q.size() == 0) chk(0, "unexpected_word", m_data_o, 0);
          else begin
            e = q.pop_front();
            chk(m_data_o == e.d, "data", m_data_o, e.d);
            chk(m_last_o == e.l, "last", m_last_o, e.l);
          end
        end
        if (aborting && m_last_o) chk(0, "last_on_abort", 1, 0);
        p_stb = wb_cyc_o & wb_stb_o;
        p_stall = stall;
        p_err = err;
        p_adr = wb_adr_o;
      end else begin
        p_stb = 1'b0;
        p_stall = 1'b0;
        p_err = 1'b0;
      end
    end
  end

  task automatic start_xfer(input int b, input int l, input int m,
                            input int e_at);
    @(posedge clk);
    #2;
    mode = m;
    err_at = e_at;
    aborting = (e_at != 0);
    exp_base = AW'(b);
    acc_cnt = 0;
    first_acc = -1;
    last_acc = -1;
    last_hs = -1;
    hs_cnt = 0;
    cyc_seen = 0;
    ack_cnt = 0;
    if (e_at == 0)
      for (int i = 0; i < l; i++)
        q.push_back('{d: mem[(b + i) % (1 << AW)], l: (i == l - 1)});
    st_cyc = cyc_n;
    start = 1'b1;
    base = AW'(b);
    len = (AW+1)'(l);
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic finish_xfer(input int l, input bit e_err, input bit tight);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (n < 4000 && !seen) begin
      @(negedge clk);
      n++;
      if (done_o) seen = 1;
    end
    chk(seen, "done_timeout", seen, 1);
    if (seen) begin
      chk(err_o == e_err, "err_flag", err_o, e_err);
      chk(busy_o == 0, "busy_at_done", busy_o, 0);
      if (e_err) chk(m_valid_o == 0, "flushed", m_valid_o, 0);
      if (l == 0) begin
        chk(n == 1, "len0_latency", n, 1);
        chk(cyc_seen == 0, "len0_nocyc", cyc_seen, 0);
      end else if (!e_err) begin
        chk(cyc_n == last_hs + 1, "done_latency", cyc_n, last_hs + 1);
        chk(acc_cnt == l, "issued", acc_cnt, l);
        chk(hs_cnt == l, "words", hs_cnt, l);
      end
      if (tight) begin
        chk(first_acc == st_cyc + 1, "stb_latency", first_acc, st_cyc + 1);
        chk(last_acc - first_acc == l - 1, "back_to_back",
            last_acc - first_acc, l - 1);
      end
    end
    @(negedge clk);
    chk(!done_o && !err_o, "done_pulse", {done_o, err_o}, 0);
    chk(q.size() == 0, "sb_empty", q.size(), 0);
    aborting = 1'b0;
    err_at = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual %0d expected %0d", 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    chk({busy_o, done_o, err_o, wb_cyc_o, wb_stb_o, m_valid_o} == 0,
        "reset_state", {busy_o, done_o, err_o, wb_cyc_o, wb_stb_o,
        m_valid_o}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk(wb_sel_o == 4'hF && wb_we_o == 0, "ties", {wb_we_o, wb_sel_o}, 4'hF);

    // 1: simple burst, always ready
    rdy_pct = 100;
    start_xfer('h010, 4, 0, 0);
    finish_xfer(4, 0, 1);

    // 2: backpressure caps the requests at FIFO depth
    rdy_pct = 0;
    start_xfer('h200, 16, 0, 0);
    repeat (20) @(negedge clk);
    chk(acc_cnt == FD, "credit_cap", acc_cnt, FD);
    chk(wb_stb_o == 0, "stb_off_full", wb_stb_o, 0);
    rdy_pct = 100;
    finish_xfer(16, 0, 0);

    // 3: classic stall=!ack slave
    start_xfer('h123, 3, 1, 0);
    finish_xfer(3, 0, 0);

    // 4: address wrap
    start_xfer('h3FFE, 4, 0, 0);
    finish_xfer(4, 0, 1);

    // 5: zero length, then bus error on the 3rd ack
    start_xfer('h050, 0, 0, 0);
    finish_xfer(0, 0, 0);
    rdy_pct = 0;
    start_xfer('h060, 8, 0, 3);
    finish_xfer(8, 1, 0);
    repeat (3) @(negedge clk);
    chk(m_valid_o == 0, "flush_stays", m_valid_o, 0);

    // 6: asynchronous reset in the middle of a read
    rdy_pct = 60;
    start_xfer('h300, 16, 2, 0);
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk({busy_o, done_o, err_o, wb_cyc_o, wb_stb_o, m_valid_o,
         m_last_o} == 0, "async_rst_ctl",
        {busy_o, done_o, err_o, wb_cyc_o, wb_stb_o, m_valid_o, m_last_o}, 0);
    chk(wb_adr_o == 0 && m_data_o == 0, "async_rst_data",
        {wb_adr_o, m_data_o}, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    rdy_pct = 100;
    start_xfer('h010, 5, 0, 0);
    finish_xfer(5, 0, 1);

    // random traffic
    for (int t = 0; t < 12; t++) begin
      rdy_pct = $urandom_range(20, 100);
      start_xfer($urandom_range(0, (1 << AW) - 1), $urandom_range(1, 40),
                 $urandom_range(0, 2), 0);
      finish_xfer(int'(len), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
